// File: rtl/alu_pkg.sv
// alu_pkg: operation and status types of the shared execute-stage ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    PASS = 3'd0,
    ADD  = 3'd1,
    SUB  = 3'd2,
    AND  = 3'd3,
    OR   = 3'd4,
    XOR  = 3'd5
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
    logic ovf;
  } alu_status_t;

endpackage

// File: rtl/mdu_pkg.sv
// mdu_pkg: operation and state types for the iterative multiply/divide sequencer.
package mdu_pkg;

  typedef enum logic [1:0] {
    MUL  = 2'd0,
    DIVU = 2'd1,
    REMU = 2'd2
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_seq.sv
// mdu_seq: shift-add multiply / restoring divide that borrows the shared ALU
// for every wide add/subtract. One iteration per RUN cycle, result returned
// through a done/result_ready handshake.
// Optional build macro: MDU_EARLY_EXIT_EN (MUL leaves RUN once the remaining
// multiplier bits are all zero).
module mdu_seq
  import alu_pkg::*;
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  mdu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             alu_req,
  output alu_op_e          alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_oe,
  input  logic [WIDTH-1:0] alu_bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  mdu_state_e       state;
  mdu_op_e          op_q;
  // MUL and DIV initialise identically (0, a, b), so one register set serves
  // both: hi_q = acc/rem, lo_q = mcand/quo, arg_q = mplier/div.
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] arg_q;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] div_t;
  logic             div_ge;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic [WIDTH-1:0] arg_nxt;
  logic             last;

  // Per-iteration next values; the wide add/subtract result comes from alu_bus.
  always_comb begin
    div_t  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    div_ge = (div_t >= arg_q);
    if (op_q == MUL) begin
      hi_nxt  = arg_q[0] ? alu_bus : hi_q;
      lo_nxt  = lo_q << 1;
      arg_nxt = arg_q >> 1;
    end else begin
      hi_nxt  = div_ge ? alu_bus : div_t;
      lo_nxt  = {lo_q[WIDTH-2:0], div_ge};
      arg_nxt = arg_q;
    end
    last = (cnt == CNT_W'(WIDTH - 1));
`ifdef MDU_EARLY_EXIT_EN
    if ((op_q == MUL) && (arg_nxt == '0)) begin
      last = 1'b1;
    end
`endif
  end

  // ALU operands are presented only while the sequencer owns the ALU.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    if (state == RUN) begin
      if (op_q == MUL) begin
        alu_a = hi_q;
        alu_b = lo_q;
      end else begin
        alu_a = div_t;
        alu_b = arg_q;
      end
    end
  end

  // Sequencer FSM, datapath registers and registered handshake/ALU controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= MUL;
      hi_q        <= '0;
      lo_q        <= '0;
      arg_q       <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      alu_req     <= 1'b0;
      alu_oe      <= 1'b0;
      alu_op      <= PASS;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            hi_q  <= '0;
            lo_q  <= a;
            arg_q <= b;
            cnt   <= '0;
            busy  <= 1'b1;
            if ((op != MUL) && (b == '0)) begin
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              result      <= (op == REMU) ? a : '1;
            end else begin
              state       <= RUN;
              div_by_zero <= 1'b0;
              alu_req     <= 1'b1;
              alu_oe      <= 1'b1;
              if (op == MUL) begin
                alu_op <= ADD;
              end else begin
                alu_op <= SUB;
              end
            end
          end
        end
        RUN: begin
          hi_q  <= hi_nxt;
          lo_q  <= lo_nxt;
          arg_q <= arg_nxt;
          cnt   <= cnt + 1'b1;
          if (last) begin
            state   <= DONE;
            done    <= 1'b1;
            alu_req <= 1'b0;
            alu_oe  <= 1'b0;
            alu_op  <= PASS;
            result  <= (op_q == DIVU) ? lo_nxt : hi_nxt;
          end
        end
        DONE: begin
          if (result_ready) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed and random checks of mdu_seq against an arithmetic
// reference model, with a behavioural model of the shared ALU on alu_bus.
module tb_mdu_seq;
  import alu_pkg::*;
  import mdu_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned W2 = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  mdu_op_e       op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic          result_ready;
  logic [W-1:0]  result;
  logic          div_by_zero;
  logic          alu_req;
  alu_op_e       alu_op;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic          alu_oe;
  logic [W-1:0]  alu_bus;

  int total = 0;
  int bad   = 0;

  mdu_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .result_ready (result_ready),
    .result       (result),
    .div_by_zero  (div_by_zero),
    .alu_req      (alu_req),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_oe       (alu_oe),
    .alu_bus      (alu_bus)
  );

  always #5 clk = ~clk;

  // Shared ALU: drives the bus only when enabled.
  always_comb begin
    alu_bus = '0;
    if (alu_oe) begin
      case (alu_op)
        ADD:     alu_bus = alu_a + alu_b;
        SUB:     alu_bus = alu_a - alu_b;
        default: alu_bus = alu_a;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input mdu_op_e o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W2-1:0] p;
    case (o)
      MUL: begin
        p = W2'(x) * W2'(y);
        return p[W-1:0];
      end
      DIVU:    return (y == '0) ? '1 : x / y;
      default: return (y == '0) ? x : x % y;
    endcase
  endfunction

  // Edges from the start-sampling edge to the edge after which done is seen.
  function automatic int ref_latency(input mdu_op_e o, input logic [W-1:0] y);
    int n;
    logic [W-1:0] v;
    if ((o != MUL) && (y == '0)) return 1;
`ifdef MDU_EARLY_EXIT_EN
    if (o == MUL) begin
      n = 0;
      v = y;
      while (v != '0) begin
        n++;
        v = v >> 1;
      end
      if (n == 0) n = 1;
      return n + 1;
    end
`endif
    return W + 1;
  endfunction

  task automatic release_result(input string tag);
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_released"}, {62'd0, busy, done}, 64'd0);
    result_ready = 1'b0;
  endtask

  // One full operation; poke > 0 pulses a conflicting start at that edge count.
  task automatic run_op(input string tag, input mdu_op_e o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int poke);
    logic [W-1:0] exp_res;
    int           exp_lat;
    int           edges;
    int           ctl_bad;
    logic         in_run;
    alu_op_e      exp_aop;
    exp_res = ref_result(o, x, y);
    exp_lat = ref_latency(o, y);
    exp_aop = (o == MUL) ? ADD : SUB;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    edges = 0;
    ctl_bad = 0;
    while (1) begin
      @(posedge clk);
      #1;
      edges++;
      start = (poke > 0) && (edges == poke);
      if (start) begin
        op = DIVU; a = 32'd1000; b = 32'd3;
      end
      in_run = busy && !done;
      if (busy !== 1'b1) ctl_bad++;
      if ((alu_req !== in_run) || (alu_oe !== in_run)) ctl_bad++;
      if (in_run && (alu_op !== exp_aop)) ctl_bad++;
      if (!in_run && (alu_op !== PASS)) ctl_bad++;
      if ((done === 1'b1) || (edges >= 200)) break;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(edges), 64'(exp_lat));
    check({tag, "_result"}, 64'(result), 64'(exp_res));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'((o != MUL) && (y == '0)));
    check({tag, "_alu_ctl"}, 64'(ctl_bad), 64'd0);
    release_result(tag);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (1) begin
      @(posedge clk);
      #1;
      n++;
      if ((done === 1'b1) || (n >= 200)) break;
    end
  endtask

  initial begin
    int           n;
    int           stab_bad;
    logic [W-1:0] exp_bp;
    mdu_op_e      ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst = 1'b1; start = 1'b0; result_ready = 1'b0;
    op = MUL; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_alu_req", 64'(alu_req), 64'd0);
    check("rst_alu_oe", 64'(alu_oe), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_alu_op", 64'(alu_op), 64'(PASS));
    check("rst_alu_ab", {alu_a, alu_b}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed operations
    run_op("mul_7x6", MUL, 32'd7, 32'd6, 0);
    run_op("mul_max", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 0);
    run_op("remu_100_7", REMU, 32'd100, 32'd7, 0);
    run_op("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("divu_by0", DIVU, 32'd5, 32'd0, 0);
    run_op("remu_by0", REMU, 32'd5, 32'd0, 0);
    run_op("mul_b0", MUL, 32'h1234_5678, 32'd0, 0);
    run_op("mul_b1", MUL, 32'h8765_4321, 32'd1, 0);
    run_op("divu_big", DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    run_op("remu_big", REMU, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    check("mul_7x6_const", 64'(ref_result(MUL, 32'd7, 32'd6)), 64'd42);

    // Start pulsed mid-RUN is ignored
    run_op("mul_poke", MUL, 32'd7, 32'd6, 2);
    run_op("divu_poke", DIVU, 32'd12345, 32'd67, 5);

    // Backpressure with a start during DONE
    exp_bp = ref_result(MUL, 32'h1234, 32'h5678);
    @(negedge clk);
    op = MUL; a = 32'h1234; b = 32'h5678; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    check("bp_done_seen", 64'(done), 64'd1);
    stab_bad = 0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      if (start) begin
        op = DIVU; a = 32'd9; b = 32'd0;
      end
      @(posedge clk);
      #1;
      if ((done !== 1'b1) || (result !== exp_bp) || (div_by_zero !== 1'b0)) stab_bad++;
    end
    start = 1'b0;
    check("bp_stable", 64'(stab_bad), 64'd0);
    @(negedge clk);
    result_ready = 1'b1;
    op = MUL; a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_after_ready", {62'd0, busy, done}, 64'd0);
    result_ready = 1'b0;
    @(posedge clk);
    #1;
    check("bp_start_next_cycle", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(n);
    check("bp_next_result", 64'(result), 64'd6);
    release_result("bp_next");

    // Reset in the middle of RUN
    @(negedge clk);
    op = MUL; a = 32'h0001_2345; b = 32'h0000_0777; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy_before_rst", {62'd0, busy, done}, 64'd2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy_done", {62'd0, busy, done}, 64'd0);
    check("mid_rst_alu_oe_req", {62'd0, alu_oe, alu_req}, 64'd0);
    check("mid_rst_alu_op", 64'(alu_op), 64'(PASS));
    check("mid_rst_result", 64'(result), 64'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_done", 64'(done), 64'd0);
    run_op("mul_3x4", MUL, 32'd3, 32'd4, 0);

    // Random operations
    for (int i = 0; i < 24; i++) begin
      ro = mdu_op_e'($urandom_range(0, 2));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), ro, ra, rb, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer that reuses the shared ALU for its add and subtract steps.
- No private wide adder; the ALU does all wide arithmetic.
- Sits beside the execute stage: CPU control issues a start, mdu_seq requests the ALU and owns its operation/operands/oe for the run, then returns the result through a done/ready handshake.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU WIDTH; power of two.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; accepted only in IDLE.
- op  input  mdu_op_e  MUL, DIVU or REMU; sampled with start.
- a  input  WIDTH  multiplicand / dividend; sampled with start.
- b  input  WIDTH  multiplier / divisor; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  high in DONE; result valid.
- result_ready  input  1  consumer accepts the result when done && result_ready.
- result  output  WIDTH  low product, quotient or remainder.
- div_by_zero  output  1  qualified by done; set for DIVU/REMU with b==0.
- alu_req  output  1  high in RUN; control muxes the ALU inputs to mdu_seq while it is high.
- alu_op  output  alu_op_e  ALU operation driven in RUN.
- alu_a  output  WIDTH  ALU a operand.
- alu_b  output  WIDTH  ALU b operand.
- alu_oe  output  1  ALU output enable; high in RUN only.
- alu_bus  input  WIDTH  ALU result bus, read combinationally in RUN.

Behaviour:
- Reset: state IDLE; busy, done, div_by_zero, alu_req, alu_oe = 0; result = 0; alu_op = PASS; alu_a/alu_b = 0; all internal registers 0.
- Reset in any state, including mid-RUN, aborts without producing a done.
- States: IDLE -> RUN -> DONE -> IDLE. Divide by zero goes IDLE -> DONE directly.
- IDLE: on start, latch op/a/b and clear the iteration counter cnt.
  - DIVU/REMU with b==0: go to DONE next cycle. result = all-ones for DIVU, a for REMU; div_by_zero = 1.
  - All other cases: go to RUN.
- start while busy is ignored; it is not queued.
- MUL in RUN, registers acc (init 0), mcand (init a), mplier (init b); one iteration per cycle:
  - alu_op = ADD, alu_a = acc, alu_b = mcand.
  - If mplier[0]: acc <= alu_bus; else acc is unchanged.
  - mcand <= mcand << 1 (local shift); mplier <= mplier >> 1.
  - Result = acc, i.e. product mod 2^WIDTH.
- DIVU/REMU in RUN, restoring division. Registers rem (init 0), quo (init a), div (init b); one iteration per cycle:
  - t = {rem[WIDTH-2:0], quo[WIDTH-1]}.
  - alu_op = SUB, alu_a = t, alu_b = div.
  - If t >= div (local unsigned compare; ALU carry is not used): rem <= alu_bus; else rem <= t.
  - quo <= {quo[WIDTH-2:0], t >= div}.
  - Result = quo for DIVU, rem for REMU.
- Counting: cnt runs 0..WIDTH-1. RUN is exactly WIDTH cycles; on cnt == WIDTH-1 go to DONE.
- Latency: start accepted at cycle 0 -> done rises at cycle WIDTH+1. Divide by zero: done at cycle 1.
- DONE: result and div_by_zero are stable. When done && result_ready, go to IDLE next cycle and drop done.
  - A start in that same cycle is ignored; it is seen next cycle in IDLE.
- All width arithmetic wraps mod 2^WIDTH. The shift of mcand discards the MSB.

Optional Feature:
- Macro MDU_EARLY_EXIT_EN.
- Defined: MUL leaves RUN at the end of any cycle where the next mplier value is 0 (mplier >> 1 == 0) or cnt == WIDTH-1.
  - A start with b==0 takes 1 RUN cycle; b==1 takes 1 RUN cycle.
  - Divide latency is unchanged.
- Undefined: MUL always takes WIDTH RUN cycles.

Decomposition:
- New mdu_pkg holds:
  - mdu_op_e (2-bit: MUL=0, DIVU=1, REMU=2).
  - mdu_state_e (IDLE, RUN, DONE).
- mdu_seq imports alu_pkg for alu_op_e; it does not use alu_status_t.
- No sub-module: the datapath registers and FSM stay in one module.

Test Plan:
- MUL a=7, b=6 -> done exactly 33 cycles after start; result=42; div_by_zero=0; alu_op=ADD, alu_oe=1, alu_req=1 for all 32 RUN cycles. With MDU_EARLY_EXIT_EN: done after 4 cycles.
- MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0x00000001. DIVU a=100, b=7 -> 14. REMU a=100, b=7 -> 2. DIVU a=0xFFFFFFFF, b=1 -> 0xFFFFFFFF.
- DIVU a=5, b=0 -> done next cycle, result=0xFFFFFFFF, div_by_zero=1, alu_req never asserted. REMU a=5, b=0 -> result=5.
- Backpressure: result_ready held 0 for 10 cycles after done -> done and result stable throughout. A start during DONE is ignored; the FSM returns to IDLE one cycle after ready.
- Pulse start mid-RUN with different operands -> ignored; original result returned.
- Assert rst at RUN cycle 10 -> next cycle busy=0, done=0, alu_oe=0, alu_op=PASS. A fresh MUL 3*4 then returns 12.
